clint_timer_unit: RTL and testbench

- Machine-level timer/software-interrupt source for the privilege block.
- Holds the 64-bit mtime and mtimecmp registers and the msip bit, all reachable through a simple word-wide register port.
- Drives the timer_int_m, soft_int_m, clear_timer_int_m and clear_soft_int_m inputs of the interrupt/exception handler.
- Sits directly upstream of the int/ex handler, between the data-bus address decoder and the priv block.

---
 rtl/clint_timer_unit.sv | 118 +++++++++++
 tb/tb_clint_timer_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer_unit.sv
// Machine timer / software-interrupt source: mtime, mtimecmp and msip behind a
// word-wide register port, driving the level and clear inputs of the int/ex handler.
module clint_timer_unit #(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned BASE_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [BASE_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic                  bus_err,
    output logic                  timer_int_m,
    output logic                  soft_int_m,
    output logic                  clear_timer_int_m,
    output logic                  clear_soft_int_m
);

    typedef enum logic {IDLE, RESP} bus_state_t;

    bus_state_t  state, state_next;
    logic [63:0] mtime, mtime_next;
    logic [63:0] mtimecmp, mtimecmp_next;
    logic        msip, msip_next;
    logic [31:0] mtime_hi_shadow, shadow_next;
    logic [15:0] presc, presc_next;
    logic        tick;
    logic [31:0] rdata_next;
    logic        bus_err_next;
    logic        timer_level;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, addr_hit;

    assign sel_msip    = (addr == BASE_WIDTH'(5'h00));
    assign sel_cmp_lo  = (addr == BASE_WIDTH'(5'h08));
    assign sel_cmp_hi  = (addr == BASE_WIDTH'(5'h0C));
    assign sel_time_lo = (addr == BASE_WIDTH'(5'h10));
    assign sel_time_hi = (addr == BASE_WIDTH'(5'h14));
    assign addr_hit    = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

    assign tick        = (presc == 16'(TICK_DIV - 1));
    assign timer_level = (mtime >= mtimecmp);
    assign ack         = (state == RESP);

    always_comb begin
        state_next    = state;
        mtimecmp_next = mtimecmp;
        msip_next     = msip;
        shadow_next   = mtime_hi_shadow;
        rdata_next    = '0;
        bus_err_next  = 1'b0;
        presc_next    = tick ? '0 : presc + 16'd1;
        mtime_next    = mtime + {63'd0, tick};

        case (state)
            IDLE: begin
                if (ren || wen) begin
                    state_next = RESP;
                    if (!addr_hit) begin
                        bus_err_next = 1'b1;
                    end else if (wen) begin
                        if (sel_msip)    msip_next            = wdata[0];
                        if (sel_cmp_lo)  mtimecmp_next[31:0]  = wdata;
                        if (sel_cmp_hi)  mtimecmp_next[63:32] = wdata;
                        // low-half write overrides the tick; high-half write keeps the
                        // ticked low half but drops its carry
                        if (sel_time_lo) mtime_next           = {mtime[63:32], wdata};
                        if (sel_time_hi) mtime_next[63:32]    = wdata;
                    end else begin
                        if (sel_msip)    rdata_next = {31'd0, msip};
                        if (sel_cmp_lo)  rdata_next = mtimecmp[31:0];
                        if (sel_cmp_hi)  rdata_next = mtimecmp[63:32];
                        if (sel_time_lo) begin
                            rdata_next  = mtime[31:0];
                            shadow_next = mtime[63:32];
                        end
                        if (sel_time_hi) rdata_next = mtime_hi_shadow;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= IDLE;
            mtime             <= '0;
            mtimecmp          <= '1;
            msip              <= 1'b0;
            mtime_hi_shadow   <= '0;
            presc             <= '0;
            rdata             <= '0;
            bus_err           <= 1'b0;
            timer_int_m       <= 1'b0;
            soft_int_m        <= 1'b0;
            clear_timer_int_m <= 1'b0;
            clear_soft_int_m  <= 1'b0;
        end else begin
            state             <= state_next;
            mtime             <= mtime_next;
            mtimecmp          <= mtimecmp_next;
            msip              <= msip_next;
            mtime_hi_shadow   <= shadow_next;
            presc             <= presc_next;
            rdata             <= rdata_next;
            bus_err           <= bus_err_next;
            timer_int_m       <= timer_level;
            soft_int_m        <= msip;
            clear_timer_int_m <= timer_int_m & ~timer_level;
            clear_soft_int_m  <= soft_int_m & ~msip;
        end
    end

endmodule

// File: tb/tb_clint_timer_unit.sv
// Scoreboard bench for clint_timer_unit: randomized and directed register traffic
// checked against a cycle-level reference model of mtime/mtimecmp/msip.
module tb_clint_timer_unit;

    localparam int unsigned TD = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, bus_err, timer_int_m, soft_int_m, clear_timer_int_m, clear_soft_int_m;

    clint_timer_unit #(.TICK_DIV(TD), .BASE_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .bus_err(bus_err),
        .timer_int_m(timer_int_m), .soft_int_m(soft_int_m),
        .clear_timer_int_m(clear_timer_int_m), .clear_soft_int_m(clear_soft_int_m)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers advanced once per clock edge.
    logic [63:0] m_time = '0;
    logic [63:0] m_cmp  = '1;
    logic [63:0] m_nxt;
    logic        m_msip = 1'b0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_r;
    int unsigned m_presc = 0;
    bit          m_busy = 1'b0;
    bit          m_tick, m_err, t_new;
    bit          e_t = 1'b0, e_s = 1'b0, e_ct = 1'b0, e_cs = 1'b0;
    logic [32:0] exp_q[$];

    always @(posedge CLK) begin
        if (RST) begin
            m_time = '0; m_cmp = '1; m_msip = 1'b0; m_shadow = '0; m_presc = 0;
            m_busy = 1'b0; e_t = 1'b0; e_s = 1'b0; e_ct = 1'b0; e_cs = 1'b0;
            exp_q.delete();
        end else begin
            t_new = (m_time >= m_cmp);
            e_ct  = e_t && !t_new;
            e_t   = t_new;
            e_cs  = e_s && !m_msip;
            e_s   = m_msip;
            m_tick  = (m_presc == TD - 1);
            m_presc = m_tick ? 0 : m_presc + 1;
            m_nxt   = m_time + (m_tick ? 64'd1 : 64'd0);
            if (m_busy) begin
                m_busy = 1'b0;
            end else if (ren || wen) begin
                m_busy = 1'b1;
                m_r    = '0;
                m_err  = 1'b0;
                if (wen) begin
                    case (addr)
                        5'h00:   m_msip = wdata[0];
                        5'h08:   m_cmp[31:0] = wdata;
                        5'h0C:   m_cmp[63:32] = wdata;
                        5'h10:   m_nxt = {m_time[63:32], wdata};
                        5'h14:   m_nxt[63:32] = wdata;
                        default: m_err = 1'b1;
                    endcase
                end else begin
                    case (addr)
                        5'h00:   m_r = {31'd0, m_msip};
                        5'h08:   m_r = m_cmp[31:0];
                        5'h0C:   m_r = m_cmp[63:32];
                        5'h10:   begin m_r = m_time[31:0]; m_shadow = m_time[63:32]; end
                        5'h14:   m_r = m_shadow;
                        default: m_err = 1'b1;
                    endcase
                end
                exp_q.push_back({m_err, m_r});
            end
            m_time = m_nxt;
        end
    end

    // Monitor: interrupt levels every cycle, responses whenever ack is presented.
    logic [32:0] popped;
    bit prev_ack = 1'b0;

    always @(negedge CLK) begin
        if (checking) begin
            chk("timer_int_m", 64'(timer_int_m), 64'(e_t));
            chk("soft_int_m", 64'(soft_int_m), 64'(e_s));
            chk("clear_timer_int_m", 64'(clear_timer_int_m), 64'(e_ct));
            chk("clear_soft_int_m", 64'(clear_soft_int_m), 64'(e_cs));
            if (ack) begin
                chk("ack_single_cycle", 64'(prev_ack), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("ack_without_request", 64'(ack), 64'd0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("rdata", 64'(rdata), 64'(popped[31:0]));
                    chk("bus_err", 64'(bus_err), 64'(popped[32]));
                end
            end
            prev_ack = ack;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic xfer(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d,
                        input bit hold, output logic [31:0] rd);
        int n;
        @(negedge CLK);
        ren = r; wen = w; addr = a; wdata = d;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!ack && n < 10);
        if (!ack) chk("ack_timeout", 64'(ack), 64'd1);
        rd = rdata;
        if (hold) @(negedge CLK);
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        xfer(1'b0, 1'b1, a, d, 1'b0, unused_rd);
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
        xfer(1'b1, 1'b0, a, 32'd0, 1'b0, d);
    endtask

    task automatic reset_outputs_zero();
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_timer_int_m", 64'(timer_int_m), 64'd0);
        chk("rst_soft_int_m", 64'(soft_int_m), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] d, lo, hi;
    int unsigned sel, kind;
    logic [4:0]  ra;
    logic [31:0] rw;
    bit          rr, rwen;

    initial begin
        repeat (3) @(negedge CLK);
        checking = 1'b1;
        reset_outputs_zero();
        RST = 1'b0;

        // 40 idle edges at TICK_DIV=4 leave mtime at 10
        idle(39);
        rd_reg(5'h10, d);
        chk("mtime_lo_after_40", 64'(d), 64'd10);

        // timer compare rise and fall
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd20);
        idle(50);
        chk("timer_after_cmp20", 64'(timer_int_m), 64'd1);
        wr(5'h08, 32'd1000);
        idle(3);
        chk("timer_after_cmp1000", 64'(timer_int_m), 64'd0);

        // software interrupt bit
        wr(5'h00, 32'd1);
        idle(2);
        wr(5'h00, 32'd0);
        idle(2);
        wr(5'h00, 32'hFFFF_FFFE);
        rd_reg(5'h00, d);
        chk("msip_only_bit0", 64'(d), 64'd0);

        // atomic 64-bit read across the low-half carry
        wr(5'h14, 32'd0);
        wr(5'h10, 32'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) begin
            rd_reg(5'h10, lo);
            rd_reg(5'h14, hi);
            chk("torn_pair", 64'((hi == 32'd0 && lo >= 32'hFFFF_FF00) ||
                                 (hi == 32'd1 && lo <  32'h0000_0100)), 64'd1);
        end

        // full 64-bit wrap with mtimecmp = 5
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd5);
        wr(5'h14, 32'hFFFF_FFFF);
        wr(5'h10, 32'hFFFF_FFFF);
        idle(12);
        rd_reg(5'h14, d);
        rd_reg(5'h10, d);
        rd_reg(5'h14, hi);
        chk("mtime_hi_after_wrap", 64'(hi), 64'd0);

        // high-half write racing a carry out of the low half
        for (int k = 0; k < 5; k++) begin
            wr(5'h10, 32'hFFFF_FFFF);
            idle(k);
            wr(5'h14, 32'd7);
            rd_reg(5'h10, d);
            rd_reg(5'h14, d);
        end

        // unmapped / misaligned accesses, and ren+wen together
        wr(5'h04, 32'h1234_5678);
        wr(5'h18, 32'h1);
        wr(5'h09, 32'hFFFF_FFFF);
        rd_reg(5'h04, d);
        rd_reg(5'h18, d);
        rd_reg(5'h09, d);
        xfer(1'b1, 1'b1, 5'h08, 32'd77, 1'b0, d);
        rd_reg(5'h08, d);
        rd_reg(5'h0C, d);
        rd_reg(5'h00, d);

        // request held into the response cycle completes only once
        xfer(1'b1, 1'b0, 5'h10, 32'd0, 1'b1, d);
        xfer(1'b0, 1'b1, 5'h08, 32'd400, 1'b1, d);

        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: ra = 5'h00;
                1: ra = 5'h08;
                2: ra = 5'h0C;
                3: ra = 5'h10;
                4: ra = 5'h14;
                5: ra = 5'h04;
                6: ra = 5'h18;
                7: ra = 5'h09;
                8: ra = 5'($urandom_range(0, 31));
                default: ra = 5'h10;
            endcase
            kind = $urandom_range(0, 5);
            rwen = (kind < 2) || (kind == 5);
            rr   = (kind >= 2);
            if (ra == 5'h0C || ra == 5'h14)
                rw = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1));
            else
                rw = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            xfer(rr, rwen, ra, rw, ($urandom_range(0, 3) == 0), d);
            idle($urandom_range(0, 3));
        end

        // reset while a request is held: no ack, registers back to reset values
        wr(5'h00, 32'd1);
        wr(5'h08, 32'd3);
        wr(5'h0C, 32'd0);
        @(negedge CLK);
        ren = 1'b1; addr = 5'h10; RST = 1'b1;
        idle(2);
        chk("ack_during_reset", 64'(ack), 64'd0);
        reset_outputs_zero();
        ren = 1'b0; RST = 1'b0;
        rd_reg(5'h00, d);
        chk("msip_after_reset", 64'(d), 64'd0);
        rd_reg(5'h08, d);
        chk("cmp_lo_after_reset", 64'(d), 64'hFFFF_FFFF);
        rd_reg(5'h0C, d);
        chk("cmp_hi_after_reset", 64'(d), 64'hFFFF_FFFF);
        rd_reg(5'h14, d);
        chk("shadow_after_reset", 64'(d), 64'd0);
        rd_reg(5'h10, d);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
